// File: rtl/bram_req_adapter.sv
`timescale 1ns/1ps
// bram_req_adapter: valid/ready request front-end for a single-port byte-write BRAM.
// Absorbs the 1-cycle read latency, range-checks addresses and returns in-order responses.
module bram_req_adapter #(
  parameter int unsigned NB_COL     = 4,
  parameter int unsigned COL_WIDTH  = 8,
  parameter int unsigned RAM_DEPTH  = 1024,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned RSP_DEPTH  = 3
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              req_valid_i,
  output logic                              req_ready_o,
  input  logic [ADDR_WIDTH-1:0]             req_addr_i,
  input  logic                              req_we_i,
  input  logic [NB_COL-1:0]                 req_be_i,
  input  logic [NB_COL*COL_WIDTH-1:0]       req_wdata_i,
  output logic                              rsp_valid_o,
  input  logic                              rsp_ready_i,
  output logic [NB_COL*COL_WIDTH-1:0]       rsp_rdata_o,
  output logic                              rsp_err_o,
  output logic                              mem_req_o,
  output logic [$clog2(RAM_DEPTH)-1:0]      mem_addr_o,
  output logic [NB_COL*COL_WIDTH-1:0]       mem_wdata_o,
  output logic [NB_COL-1:0]                 mem_bwe_o,
  input  logic [NB_COL*COL_WIDTH-1:0]       mem_rdata_i
);
  localparam int unsigned DW  = NB_COL * COL_WIDTH;
  localparam int unsigned MW  = $clog2(RAM_DEPTH);
  localparam int unsigned OFS = $clog2(NB_COL);
  localparam int unsigned UW  = ADDR_WIDTH - OFS;
  localparam int unsigned PW  = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int unsigned CW  = $clog2(RSP_DEPTH + 1);
  localparam int unsigned CW1 = CW + 1;

  typedef struct packed {
    logic          err;
    logic [DW-1:0] data;
  } rsp_t;

  logic          in_range_c;
  logic          accept;
  logic          s1_valid;
  logic          s1_we;
  logic          s1_err;
  logic          push;
  logic          pop;
  rsp_t          push_data;
  rsp_t          fifo_mem [RSP_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          unused_addr_lsbs;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Credit check: an accepted request always has a FIFO slot waiting for it.
  assign in_range_c  = req_addr_i[ADDR_WIDTH-1:OFS] < UW'(RAM_DEPTH);
  assign req_ready_o = !rst_i && (({1'b0, count} + CW1'(s1_valid)) < CW1'(RSP_DEPTH));
  assign accept      = req_valid_i && req_ready_o;

  assign mem_req_o   = accept && in_range_c;
  assign mem_addr_o  = req_addr_i[OFS +: MW];
  assign mem_wdata_o = req_wdata_i;
  assign mem_bwe_o   = req_we_i ? req_be_i : '0;

  assign unused_addr_lsbs = ^req_addr_i[OFS-1:0];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_valid <= 1'b0;
      s1_we    <= 1'b0;
      s1_err   <= 1'b0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_we  <= req_we_i;
        s1_err <= !in_range_c;
      end
    end
  end

  // BRAM read data is only meaningful the cycle after a successful read access.
  assign push           = s1_valid;
  assign pop            = rsp_valid_o && rsp_ready_i;
  assign push_data.err  = s1_err;
  assign push_data.data = (s1_we || s1_err) ? '0 : mem_rdata_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)      count <= count + CW'(1);
      else if (!push && pop) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr] <= push_data;
  end

  assign rsp_valid_o = (count != '0);
  assign rsp_rdata_o = fifo_mem[rd_ptr].data;
  assign rsp_err_o   = fifo_mem[rd_ptr].err;

endmodule

// File: tb/tb_bram_req_adapter.sv
`timescale 1ns/1ps
// Bench for bram_req_adapter: table vectors, directed latency/backpressure/reset sequences
// and random traffic checked against a transaction-level memory model.
module tb_bram_req_adapter;
  localparam int unsigned DEPTH = 1024;
  localparam logic [31:0] LIMIT = 32'h1000;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [31:0] req_addr_i;
  logic        req_we_i;
  logic [3:0]  req_be_i;
  logic [31:0] req_wdata_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic        mem_req_o;
  logic [9:0]  mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_bwe_o;
  logic [31:0] mem_rdata_i;

  int errors = 0;
  int checks = 0;

  bram_req_adapter dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
    .req_we_i(req_we_i), .req_be_i(req_be_i), .req_wdata_i(req_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
    .rsp_err_o(rsp_err_o), .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_bwe_o(mem_bwe_o), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Read-first byte-write BRAM
  logic [31:0] bram [DEPTH];
  always @(posedge clk_i) begin
    if (mem_req_o) begin
      mem_rdata_i <= bram[mem_addr_o];
      for (int b = 0; b < 4; b++)
        if (mem_bwe_o[b]) bram[mem_addr_o][b*8 +: 8] <= mem_wdata_o[b*8 +: 8];
    end
  end

  // Transaction-level reference: memory image plus queue of expected responses
  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] ref_mem [DEPTH];
  logic        hold_prev = 1'b0;
  logic [31:0] hold_data;
  logic        hold_err;

  always @(negedge clk_i) begin
    logic exp_rdy, acc, inr;
    int unsigned w;
    exp_t e;
    if (rst_i) begin
      chk("rst_req_ready", 64'(req_ready_o), 64'd0);
      chk("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
      exp_q.delete();
      hold_prev = 1'b0;
    end else begin
      exp_rdy = (exp_q.size() < 3);
      inr     = (req_addr_i < LIMIT);
      acc     = req_valid_i && exp_rdy;
      w       = req_addr_i / 4;
      chk("req_ready", 64'(req_ready_o), 64'(exp_rdy));
      chk("mem_req", 64'(mem_req_o), 64'(acc && inr));
      if (acc && inr)
        chk("mem_port", 64'({mem_addr_o, mem_bwe_o, mem_wdata_o}),
            64'({10'(w), (req_we_i ? req_be_i : 4'h0), req_wdata_i}));
      if (hold_prev) begin
        chk("rsp_hold_valid", 64'(rsp_valid_o), 64'd1);
        chk("rsp_hold_data", 64'({rsp_rdata_o, rsp_err_o}), 64'({hold_data, hold_err}));
      end
      chk("rsp_spurious", 64'(rsp_valid_o && (exp_q.size() == 0)), 64'd0);
      if (rsp_valid_o && rsp_ready_i && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("rsp_data", 64'({rsp_rdata_o, rsp_err_o}), 64'({e.data, e.err}));
      end
      if (acc) begin
        if (!inr)          e = '{data: 32'h0, err: 1'b1};
        else if (req_we_i) begin
          e = '{data: 32'h0, err: 1'b0};
          for (int b = 0; b < 4; b++)
            if (req_be_i[b]) ref_mem[w][b*8 +: 8] = req_wdata_i[b*8 +: 8];
        end else           e = '{data: ref_mem[w], err: 1'b0};
        exp_q.push_back(e);
      end
      hold_prev = rsp_valid_o && !rsp_ready_i;
      hold_data = rsp_rdata_o;
      hold_err  = rsp_err_o;
    end
  end

  task automatic send(input logic [31:0] a, input logic we, input logic [3:0] be,
                      input logic [31:0] d, input bit rnd);
    bit acc = 1'b0;
    int t = 0;
    req_valid_i = 1'b1; req_addr_i = a; req_we_i = we; req_be_i = be; req_wdata_i = d;
    while (!acc && t < 50) begin
      if (rnd) rsp_ready_i = ($urandom_range(0, 1) == 1);
      @(negedge clk_i);
      acc = req_ready_o;
      @(posedge clk_i); #1;
      t++;
    end
    req_valid_i = 1'b0;
    chk("send_accept", 64'(acc), 64'd1);
  endtask

  task automatic drain();
    int t = 0;
    req_valid_i = 1'b0;
    rsp_ready_i = 1'b1;
    while (exp_q.size() != 0 && t < 30) begin
      @(posedge clk_i); #1;
      t++;
    end
    @(negedge clk_i);
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
    @(posedge clk_i); #1;
  endtask

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  function automatic vec_t mk(input string n, input logic [31:0] a, input logic we,
                              input logic [3:0] be, input logic [31:0] d,
                              input logic [31:0] er, input logic ee);
    vec_t v;
    v.name = n; v.addr = a; v.we = we; v.be = be; v.wdata = d;
    v.exp_rdata = er; v.exp_err = ee;
    return v;
  endfunction

  task automatic do_vec(input vec_t v);
    bit got = 1'b0;
    int t = 0;
    logic [31:0] r = '0;
    logic        e = 1'b0;
    rsp_ready_i = 1'b1;
    send(v.addr, v.we, v.be, v.wdata, 1'b0);
    while (!got && t < 20) begin
      @(negedge clk_i);
      if (rsp_valid_o) begin
        got = 1'b1; r = rsp_rdata_o; e = rsp_err_o;
      end
      @(posedge clk_i); #1;
      t++;
    end
    chk({v.name, "_rsp_seen"}, 64'(got), 64'd1);
    chk({v.name, "_rdata"}, 64'(r), 64'(v.exp_rdata));
    chk({v.name, "_err"}, 64'(e), 64'(v.exp_err));
  endtask

  vec_t vecs[9];

  initial begin
    int n_acc, n_rsp, first_rsp, last_rsp, last_acc;
    logic [31:0] last_d;

    for (int i = 0; i < DEPTH; i++) begin
      bram[i] = '0;
      ref_mem[i] = '0;
    end
    mem_rdata_i = '0;
    rst_i = 1'b1;
    req_valid_i = 1'b0; req_addr_i = '0; req_we_i = 1'b0; req_be_i = '0; req_wdata_i = '0;
    rsp_ready_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;

    vecs[0] = mk("wr10",      32'h10,       1'b1, 4'b0101, 32'hAABBCCDD, 32'h0,        1'b0);
    vecs[1] = mk("rd10",      32'h10,       1'b0, 4'h0,    32'h0,        32'h00BB00DD, 1'b0);
    vecs[2] = mk("rd_oor",    32'h1000,     1'b0, 4'h0,    32'h0,        32'h0,        1'b1);
    vecs[3] = mk("wr_oor",    32'h1000,     1'b1, 4'hF,    32'hFFFFFFFF, 32'h0,        1'b1);
    vecs[4] = mk("rd0_alias", 32'h0,        1'b0, 4'h0,    32'h0,        32'h0,        1'b0);
    vecs[5] = mk("wr13",      32'h13,       1'b1, 4'b1010, 32'h11223344, 32'h0,        1'b0);
    vecs[6] = mk("rd12",      32'h12,       1'b0, 4'h0,    32'h0,        32'h11BB33DD, 1'b0);
    vecs[7] = mk("rd_last",   32'hFFC,      1'b0, 4'h0,    32'h0,        32'h0,        1'b0);
    vecs[8] = mk("wr_top",    32'hFFFFFFFC, 1'b1, 4'hF,    32'h12345678, 32'h0,        1'b1);
    for (int i = 0; i < 9; i++) do_vec(vecs[i]);
    drain();

    // Back-to-back reads with consumer always ready
    n_acc = 0; n_rsp = 0; first_rsp = -1; last_rsp = -1; last_acc = -1;
    rsp_ready_i = 1'b1;
    for (int c = 0; c < 14; c++) begin
      req_valid_i = (n_acc < 8); req_we_i = 1'b0; req_addr_i = 32'(n_acc * 4);
      @(negedge clk_i);
      if (req_valid_i && req_ready_o) begin
        n_acc++; last_acc = c;
      end
      if (rsp_valid_o) begin
        if (first_rsp < 0) first_rsp = c;
        last_rsp = c; n_rsp++;
      end
      @(posedge clk_i); #1;
    end
    req_valid_i = 1'b0;
    chk("b2b_accepts", 64'(n_acc), 64'd8);
    chk("b2b_last_acc", 64'(last_acc), 64'd7);
    chk("b2b_first_rsp", 64'(first_rsp), 64'd2);
    chk("b2b_last_rsp", 64'(last_rsp), 64'd9);
    chk("b2b_rsp_count", 64'(n_rsp), 64'd8);
    drain();

    // Backpressure: only RSP_DEPTH accepts while the consumer stalls
    rsp_ready_i = 1'b0; n_acc = 0;
    req_we_i = 1'b0;
    for (int c = 0; c < 8; c++) begin
      req_valid_i = 1'b1; req_addr_i = 32'h10 + 32'(n_acc * 4);
      @(negedge clk_i);
      if (req_ready_o) n_acc++;
      @(posedge clk_i); #1;
    end
    @(negedge clk_i);
    chk("bp_accepts", 64'(n_acc), 64'd3);
    chk("bp_ready_low", 64'(req_ready_o), 64'd0);
    chk("bp_rsp_valid", 64'(rsp_valid_o), 64'd1);
    @(posedge clk_i); #1;
    rsp_ready_i = 1'b1;
    for (int c = 0; c < 8; c++) begin
      req_addr_i = 32'h10 + 32'(n_acc * 4);
      @(negedge clk_i);
      if (req_ready_o) n_acc++;
      @(posedge clk_i); #1;
    end
    chk("bp_resume", 64'(n_acc > 3), 64'd1);
    drain();

    // Reset with 2 responses queued and 1 in flight
    rsp_ready_i = 1'b0;
    send(32'h10, 1'b0, 4'h0, 32'h0, 1'b0);
    send(32'h14, 1'b0, 4'h0, 32'h0, 1'b0);
    send(32'h18, 1'b0, 4'h0, 32'h0, 1'b0);
    rst_i = 1'b1;
    #1;
    chk("rst_mid_rsp_valid", 64'(rsp_valid_o), 64'd0);
    chk("rst_mid_req_ready", 64'(req_ready_o), 64'd0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    rsp_ready_i = 1'b1;
    @(negedge clk_i);
    chk("rst_rel_req_ready", 64'(req_ready_o), 64'd1);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk_i);
      chk("rst_no_stale", 64'(rsp_valid_o), 64'd0);
    end
    @(posedge clk_i); #1;

    // Alternating write/read to one word with a random consumer
    last_d = '0;
    for (int i = 0; i < 16; i++) begin
      last_d = $urandom;
      send(32'h40, 1'b1, 4'hF, last_d, 1'b1);
      send(32'h40, 1'b0, 4'h0, 32'h0, 1'b1);
    end
    drain();
    do_vec(mk("raw_final", 32'h40, 1'b0, 4'h0, 32'h0, last_d, 1'b0));
    drain();

    // Random traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      req_valid_i = ($urandom_range(0, 3) != 0);
      req_we_i    = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 9))
        0:       req_addr_i = LIMIT | $urandom;
        1:       req_addr_i = 32'hFFC + 32'($urandom_range(0, 3));
        default: req_addr_i = 32'($urandom_range(0, 7) * 4 + $urandom_range(0, 3));
      endcase
      req_be_i    = 4'($urandom);
      req_wdata_i = $urandom;
      rsp_ready_i = ($urandom_range(0, 3) != 0);
      @(posedge clk_i); #1;
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
